// File: rtl/multiplier_pipelined_nbits.sv
// Streaming WIDTH x WIDTH -> 2*WIDTH multiplier, signed or unsigned per operation.
// Baugh-Wooley partial products, carry-save row reduction, Kogge-Stone final adder.
module multiplier_pipelined_nbits #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic                 in_signed_i,
  input  logic [WIDTH-1:0]     in_a_i,
  input  logic [WIDTH-1:0]     in_b_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [2*WIDTH-1:0]   out_product_o
);

  localparam int W       = int'(WIDTH);
  localparam int P       = 2 * W;
  localparam int NChunk  = int'(STAGES) - 1;
  localparam int Per     = (NChunk <= 0) ? 0 : (W - 1 + NChunk - 1) / NChunk;
  localparam int FinalLo = (2 + NChunk * Per > W + 1) ? W + 1 : 2 + NChunk * Per;

  typedef logic [P-1:0] row_t;

  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("WIDTH must be in 4..32");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("STAGES must be in 1..4");
  end

  // Row j < W holds a[i]&b[j] at column i+j; row W is the signed-mode constant.
  function automatic row_t pp_row(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sg, input int j);
    row_t row;
    logic bit_v;
    row = '0;
    if (j == W) begin
      if (sg) begin
        row[W]   = 1'b1;
        row[P-1] = 1'b1;
      end
    end else begin
      for (int i = 0; i < W; i++) begin
        bit_v = a[i] & b[j];
        if (sg && ((i == W - 1) != (j == W - 1))) bit_v = ~bit_v;
        row[i+j] = bit_v;
      end
    end
    return row;
  endfunction

  // Folds rows lo..hi-1 into the (sum, carry) pair; each column is two half adders.
  function automatic logic [2*P-1:0] csa_range(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic sg, input row_t s_in,
                                               input row_t c_in, input int lo, input int hi);
    row_t s, c, r, s1, c1, c2;
    s  = s_in;
    c  = c_in;
    r  = '0;
    s1 = '0;
    c1 = '0;
    c2 = '0;
    for (int j = 2; j <= W; j++) begin
      if (j >= lo && j < hi) begin
        r  = pp_row(a, b, sg, j);
        s1 = s ^ c;
        c1 = s & c;
        s  = s1 ^ r;
        c2 = s1 & r;
        c  = (c1 | c2) << 1;
      end
    end
    return {s, c};
  endfunction

  function automatic row_t ks_add(input row_t x, input row_t y);
    row_t g, p, p0, gn, pn;
    g  = x & y;
    p  = x ^ y;
    p0 = p;
    for (int d = 1; d < P; d = d * 2) begin
      gn = g;
      pn = p;
      for (int i = d; i < P; i++) begin
        gn[i] = g[i] | (p[i] & g[i-d]);
        pn[i] = p[i] & p[i-d];
      end
      g = gn;
      p = pn;
    end
    return p0 ^ {g[P-2:0], 1'b0};
  endfunction

  logic adv;
  logic out_valid_q;
  row_t out_product_q;
  row_t prod_d;
  row_t fin_s, fin_c;
  logic [2*P-1:0] fin_sc;

  // All stages move together; bubbles travel with their slot.
  assign adv           = !out_valid_q | out_ready_i;
  assign in_ready_o    = adv;
  assign out_valid_o   = out_valid_q;
  assign out_product_o = out_product_q;

  // Tap 0 is the input port; taps 1..STAGES-1 are the reduction registers.
  for (genvar k = 0; k < int'(STAGES); k++) begin : g_st
    logic           v;
    logic [W-1:0]   a, b;
    logic           sg;
    row_t           s, c;

    if (k == 0) begin : g_entry
      assign v  = in_valid_i;
      assign a  = in_a_i;
      assign b  = in_b_i;
      assign sg = in_signed_i;
      assign s  = pp_row(in_a_i, in_b_i, in_signed_i, 0);
      assign c  = pp_row(in_a_i, in_b_i, in_signed_i, 1);
    end else begin : g_reg
      localparam int Lo = 2 + (k - 1) * Per;
      localparam int Hi = (Lo + Per > W + 1) ? W + 1 : Lo + Per;
      logic [2*P-1:0] sc_d;

      assign sc_d = csa_range(g_st[k-1].a, g_st[k-1].b, g_st[k-1].sg,
                              g_st[k-1].s, g_st[k-1].c, Lo, Hi);

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          v <= 1'b0;
        end else if (adv) begin
          v <= g_st[k-1].v;
        end
      end

      always_ff @(posedge clk_i) begin
        if (adv && g_st[k-1].v) begin
          a      <= g_st[k-1].a;
          b      <= g_st[k-1].b;
          sg     <= g_st[k-1].sg;
          {s, c} <= sc_d;
        end
      end
    end
  end

  assign fin_sc = csa_range(g_st[STAGES-1].a, g_st[STAGES-1].b, g_st[STAGES-1].sg,
                            g_st[STAGES-1].s, g_st[STAGES-1].c, FinalLo, W + 1);
  assign {fin_s, fin_c} = fin_sc;
  assign prod_d = ks_add(fin_s, fin_c);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
    end else if (adv) begin
      out_valid_q <= g_st[STAGES-1].v;
      if (g_st[STAGES-1].v) out_product_q <= prod_d;
    end
  end

endmodule

// File: tb/tb_multiplier_pipelined_nbits.sv
// Directed and scoreboarded checks of multiplier_pipelined_nbits at WIDTH=8, STAGES=3.
module tb_multiplier_pipelined_nbits;

  localparam int W = 8;
  localparam int S = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_signed;
  logic [W-1:0]  in_a, in_b;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] out_product;

  int total = 0;
  int bad   = 0;

  multiplier_pipelined_nbits #(
    .WIDTH (W),
    .STAGES(S)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .in_signed_i  (in_signed),
    .in_a_i       (in_a),
    .in_b_i       (in_b),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_product_o(out_product)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic sg);
    logic signed [15:0] sa, sb;
    if (sg) begin
      sa = {{8{a[7]}}, a};
      sb = {{8{b[7]}}, b};
      return sa * sb;
    end
    return {8'h00, a} * {8'h00, b};
  endfunction

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_signed = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    #12;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b want=0", out_valid);
    end
    total++;
    if (out_product !== 16'h0000) begin
      bad++; $display("FAIL reset_product got=%h want=0000", out_product);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned_corners();
    logic [7:0]  va [3] = '{8'hFF, 8'h00, 8'h01};
    logic [7:0]  vb [3] = '{8'hFF, 8'hA5, 8'h80};
    logic [15:0] ve [3] = '{16'hFE01, 16'h0000, 16'h0080};
    logic exp_v;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid  = (i < 3);
      in_signed = 1'b0;
      in_a      = (i < 3) ? va[i] : 8'h00;
      in_b      = (i < 3) ? vb[i] : 8'h00;
      @(negedge clk);
      exp_v = (i >= 3 && i < 6);
      total++;
      if (out_valid !== exp_v) begin
        bad++; $display("FAIL corners_valid cyc=%0d got=%b want=%b", i, out_valid, exp_v);
      end
      if (exp_v) begin
        total++;
        if (out_product !== ve[i-3]) begin
          bad++; $display("FAIL corners_product cyc=%0d got=%h want=%h", i, out_product, ve[i-3]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mode_per_txn();
    logic        vs [3] = '{1'b1, 1'b0, 1'b1};
    logic [7:0]  va [3] = '{8'hFF, 8'hFF, 8'h80};
    logic [7:0]  vb [3] = '{8'h01, 8'h01, 8'h80};
    logic [15:0] ve [3] = '{16'hFFFF, 16'h00FF, 16'h4000};
    logic exp_v;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid  = (i < 3);
      // Flip the mode input after the last accept; in-flight products must ignore it.
      in_signed = (i < 3) ? vs[i] : 1'b0;
      in_a      = (i < 3) ? va[i] : 8'h00;
      in_b      = (i < 3) ? vb[i] : 8'h00;
      @(negedge clk);
      exp_v = (i >= 3 && i < 6);
      total++;
      if (out_valid !== exp_v) begin
        bad++; $display("FAIL mode_valid cyc=%0d got=%b want=%b", i, out_valid, exp_v);
      end
      if (exp_v) begin
        total++;
        if (out_product !== ve[i-3]) begin
          bad++; $display("FAIL mode_product cyc=%0d got=%h want=%h", i, out_product, ve[i-3]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0]  va [6] = '{8'h02, 8'h10, 8'hFF, 8'h7F, 8'hC8, 8'h80};
    logic [7:0]  vb [6] = '{8'h03, 8'h10, 8'hFF, 8'h80, 8'h64, 8'h7F};
    logic        vs [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] ve [6] = '{16'h0006, 16'h0100, 16'h0001, 16'hC080, 16'h4E20, 16'h3F80};
    int n_sent = 0;
    int n_recv = 0;
    logic held = 1'b0;
    logic [15:0] held_p = '0;
    logic exp_rdy;
    for (int c = 0; c < 16; c++) begin
      out_ready = !(c >= 4 && c <= 7);
      in_valid  = (n_sent < 6);
      in_a      = (n_sent < 6) ? va[n_sent] : 8'h00;
      in_b      = (n_sent < 6) ? vb[n_sent] : 8'h00;
      in_signed = (n_sent < 6) ? vs[n_sent] : 1'b0;
      @(negedge clk);
      exp_rdy = !(c >= 4 && c <= 7);
      total++;
      if (in_ready !== exp_rdy) begin
        bad++; $display("FAIL bp_in_ready cyc=%0d got=%b want=%b", c, in_ready, exp_rdy);
      end
      if (held) begin
        total++;
        if (out_valid !== 1'b1 || out_product !== held_p) begin
          bad++;
          $display("FAIL bp_hold cyc=%0d got=%b/%h want=1/%h", c, out_valid, out_product, held_p);
        end
      end
      held   = out_valid && !out_ready;
      held_p = out_product;
      if (out_valid && out_ready) begin
        total++;
        if (n_recv >= 6) begin
          bad++; $display("FAIL bp_extra cyc=%0d got=%h want=none", c, out_product);
        end else if (out_product !== ve[n_recv]) begin
          bad++;
          $display("FAIL bp_product idx=%0d got=%h want=%h", n_recv, out_product, ve[n_recv]);
        end
        n_recv++;
      end
      if (in_valid && in_ready) n_sent++;
      @(posedge clk); #1;
    end
    total++;
    if (n_recv != 6) begin
      bad++; $display("FAIL bp_count got=%0d want=6", n_recv);
    end
  endtask

  task automatic test_bubbles();
    logic        pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic        vs  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0]  va  [4] = '{8'h03, 8'hAA, 8'h7F, 8'hFE};
    logic [7:0]  vb  [4] = '{8'h05, 8'h55, 8'h7F, 8'h03};
    logic [15:0] ve  [4] = '{16'h000F, 16'h0000, 16'h3F01, 16'hFFFA};
    logic exp_v;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid  = (i < 4) ? pat[i] : 1'b0;
      in_signed = (i < 4) ? vs[i] : 1'b0;
      in_a      = (i < 4) ? va[i] : 8'h00;
      in_b      = (i < 4) ? vb[i] : 8'h00;
      @(negedge clk);
      exp_v = (i >= 3 && i < 7) ? pat[i-3] : 1'b0;
      total++;
      if (out_valid !== exp_v) begin
        bad++; $display("FAIL bubble_valid cyc=%0d got=%b want=%b", i, out_valid, exp_v);
      end
      if (exp_v) begin
        total++;
        if (out_product !== ve[i-3]) begin
          bad++; $display("FAIL bubble_product cyc=%0d got=%h want=%h", i, out_product, ve[i-3]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid  = (i < 3);
      in_signed = 1'b0;
      in_a      = 8'(i + 2);
      in_b      = 8'h11;
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_product !== 16'h0022) begin
      bad++; $display("FAIL rst_pre got=%b/%h want=1/0022", out_valid, out_product);
    end
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_product !== 16'h0000) begin
      bad++; $display("FAIL rst_async got=%b/%h want=0/0000", out_valid, out_product);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) begin
        bad++; $display("FAIL rst_stale cyc=%0d got=%b/%h want=0", i, out_valid, out_product);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random_stream();
    logic [15:0] sb [$];
    logic [15:0] exp_p;
    int n_sent = 0;
    int n_recv = 0;
    for (int c = 0; c < 4000 && n_recv < 400; c++) begin
      in_valid  = (n_sent < 400) && ($urandom_range(0, 3) != 0);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      in_signed = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) begin
        sb.push_back(model(in_a, in_b, in_signed));
        n_sent++;
      end
      if (out_valid && out_ready) begin
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL rand_spurious got=%h want=none", out_product);
        end else begin
          exp_p = sb.pop_front();
          if (out_product !== exp_p) begin
            bad++; $display("FAIL rand_product idx=%0d got=%h want=%h", n_recv, out_product, exp_p);
          end
        end
        n_recv++;
      end
      @(posedge clk); #1;
    end
    total++;
    if (n_recv != 400) begin
      bad++; $display("FAIL rand_count got=%0d want=400", n_recv);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_corners();
    test_mode_per_txn();
    test_bubbles();
    test_backpressure();
    test_reset_midflight();
    test_random_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
